// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded instruction fields into instruction words
// and streams them into instruction memory through a registered write port.
// A session opened by start and closed by finish writes at most DEPTH words,
// starting at BASEADDRESS and wrapping modulo the memory address space.
module instruction_encoder #(
  parameter int INSTRUCTIONWIDTH = 16,
  parameter int OPCODEWIDTH      = 4,
  parameter int ADDRESSWIDTH     = 4,
  parameter int MEMADDRWIDTH     = 8,
  parameter int DEPTH            = 256,
  parameter int BASEADDRESS      = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        finish,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic                        immFormat,
  input  logic [OPCODEWIDTH-1:0]      opcode,
  input  logic [ADDRESSWIDTH-1:0]     rd,
  input  logic [ADDRESSWIDTH-1:0]     rs1,
  input  logic [ADDRESSWIDTH-1:0]     rs2,
  input  logic [7:0]                  imm,
  output logic                        memWriteEnable,
  output logic [MEMADDRWIDTH-1:0]     memAddress,
  output logic [INSTRUCTIONWIDTH-1:0] memData,
  output logic [MEMADDRWIDTH:0]       wordCount,
  output logic                        busy,
  output logic                        full,
  output logic                        done,
  output logic                        error
);

  localparam logic [MEMADDRWIDTH-1:0] BASE_A  = MEMADDRWIDTH'(BASEADDRESS);
  localparam logic [MEMADDRWIDTH:0]   DEPTH_C = (MEMADDRWIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                      state_q;
  logic [MEMADDRWIDTH-1:0]     ptr_q;
  logic [MEMADDRWIDTH:0]       count_q;
  logic                        we_q;
  logic [MEMADDRWIDTH-1:0]     addr_q;
  logic [INSTRUCTIONWIDTH-1:0] data_q;
  logic                        error_q;
  logic                        ready_q;
  logic                        busy_q;
  logic                        full_q;
  logic                        done_q;

  logic                        accept;
  logic [INSTRUCTIONWIDTH-1:0] word_d;

  // ready_q is only set in RUN, where the count is always below DEPTH
  assign accept = inValid && ready_q;

  // Pack the field bundle into the selected instruction format
  always_comb begin
    word_d = '0;
    if (immFormat) begin
      word_d = INSTRUCTIONWIDTH'({opcode, rd, imm});
    end else begin
      word_d = INSTRUCTIONWIDTH'({opcode, rd, rs2, rs1});
    end
  end

  // Session FSM, write port, counters and registered status flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= BASE_A;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_A;
      data_q  <= '0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q <= accept;
      if (accept) begin
        addr_q <= ptr_q;
        data_q <= word_d;
        ptr_q  <= ptr_q + 1'b1;
        if (count_q != DEPTH_C) begin
          count_q <= count_q + 1'b1;
        end
      end
      // Offering a bundle while not ready is an overrun or an out-of-session write
      if (inValid && !ready_q) begin
        error_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            ptr_q   <= BASE_A;
            count_q <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // finish wins over filling up; a same-cycle accept is still written
          if (finish) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (accept && ((count_q + 1'b1) == DEPTH_C)) begin
            state_q <= FULL;
            ready_q <= 1'b0;
            full_q  <= 1'b1;
          end
        end
        FULL: begin
          if (finish) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          full_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign inReady        = ready_q;
  assign memWriteEnable = we_q;
  assign memAddress     = addr_q;
  assign memData        = data_q;
  assign wordCount      = count_q;
  assign busy           = busy_q;
  assign full           = full_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: three instances (default, DEPTH=4, DEPTH=4
// based at 8'hFE) share one stimulus stream; directed scenarios plus a
// randomized run compared against a session-level reference model.
module tb_instruction_encoder;

  localparam int N = 3;
  localparam int DEP [N] = '{256, 4, 4};
  localparam int BAS [N] = '{0, 0, 254};

  logic       clock = 1'b0;
  logic       reset, start, finish, inValid, immFormat;
  logic [3:0] opcode, rd, rs1, rs2;
  logic [7:0] imm;

  logic        rdy  [N];
  logic        we   [N];
  logic [7:0]  addr [N];
  logic [15:0] data [N];
  logic [8:0]  wc   [N];
  logic        bsy  [N];
  logic        ful  [N];
  logic        dn   [N];
  logic        err  [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  instruction_encoder u0 (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .inValid(inValid), .inReady(rdy[0]), .immFormat(immFormat),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .memWriteEnable(we[0]), .memAddress(addr[0]), .memData(data[0]),
    .wordCount(wc[0]), .busy(bsy[0]), .full(ful[0]), .done(dn[0]), .error(err[0])
  );

  instruction_encoder #(.DEPTH(4)) u1 (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .inValid(inValid), .inReady(rdy[1]), .immFormat(immFormat),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .memWriteEnable(we[1]), .memAddress(addr[1]), .memData(data[1]),
    .wordCount(wc[1]), .busy(bsy[1]), .full(ful[1]), .done(dn[1]), .error(err[1])
  );

  instruction_encoder #(.DEPTH(4), .BASEADDRESS(254)) u2 (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .inValid(inValid), .inReady(rdy[2]), .immFormat(immFormat),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .memWriteEnable(we[2]), .memAddress(addr[2]), .memData(data[2]),
    .wordCount(wc[2]), .busy(bsy[2]), .full(ful[2]), .done(dn[2]), .error(err[2])
  );

  // Reference model: a session is "open" from start until finish; the encoder
  // is ready while a session is open and fewer than DEPTH words were taken.
  // The k-th word of a session goes to (BASE + k) mod 256.
  bit m_open [N];
  bit m_end  [N];
  bit m_err  [N];
  bit m_we   [N];
  int m_cnt  [N];
  int m_addr [N];
  int m_data [N];

  function automatic bit m_ready(int k);
    return m_open[k] && (m_cnt[k] < DEP[k]);
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < N; k++) begin
      automatic bit rk  = m_ready(k);
      automatic bit acc = inValid && rk;
      if (!reset) begin
        m_open[k] <= 1'b0; m_end[k] <= 1'b0; m_err[k] <= 1'b0; m_we[k] <= 1'b0;
        m_cnt[k]  <= 0;    m_addr[k] <= BAS[k]; m_data[k] <= 0;
      end else begin
        m_we[k] <= acc;
        if (acc) begin
          m_addr[k] <= (BAS[k] + m_cnt[k]) % 256;
          m_data[k] <= immFormat ? (int'(opcode) * 4096 + int'(rd) * 256 + int'(imm))
                                 : (int'(opcode) * 4096 + int'(rd) * 256 + int'(rs2) * 16 + int'(rs1));
          m_cnt[k]  <= m_cnt[k] + 1;
        end
        if (!m_open[k] && !m_end[k] && start) begin
          m_open[k] <= 1'b1;
          m_cnt[k]  <= 0;
          m_err[k]  <= 1'b0;
        end else if (inValid && !rk) begin
          m_err[k] <= 1'b1;
        end
        if (m_open[k] && finish) begin
          m_open[k] <= 1'b0;
          m_end[k]  <= 1'b1;
        end
        if (m_end[k]) m_end[k] <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    start = 0; finish = 0; inValid = 0; immFormat = 0;
    opcode = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic close_session();
    inValid = 0;
    finish = 1;
    tick();
    finish = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (rdy[k] !== 1'b0 || we[k] !== 1'b0 || addr[k] !== 8'(BAS[k]) || data[k] !== 16'h0 ||
          wc[k] !== 9'd0 || bsy[k] !== 1'b0 || ful[k] !== 1'b0 || dn[k] !== 1'b0 || err[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: rdy=%b we=%b addr=%h data=%h wc=%0d busy=%b full=%b done=%b err=%b, want all zero, addr=%h",
                 k, rdy[k], we[k], addr[k], data[k], wc[k], bsy[k], ful[k], dn[k], err[k], 8'(BAS[k]));
      end
    end
    reset = 1;
    tick();
  endtask

  task automatic test_register_encode();
    pulse_start();
    vectors++;
    if (rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ready: inReady=%b want 1", rdy[0]);
    end
    inValid = 1; immFormat = 0; opcode = 4'h2; rd = 4'd3; rs2 = 4'd5; rs1 = 4'd1; imm = 8'hAA;
    tick();
    inValid = 0;
    vectors++;
    if (we[0] !== 1'b1 || addr[0] !== 8'h00 || data[0] !== 16'h2351 || wc[0] !== 9'd1) begin
      miscompares++;
      $display("FAIL reg_encode: we=%b addr=%h data=%h wc=%0d want 1 00 2351 1", we[0], addr[0], data[0], wc[0]);
    end
    tick();
    vectors++;
    if (we[0] !== 1'b0 || data[0] !== 16'h2351) begin
      miscompares++;
      $display("FAIL reg_hold: we=%b data=%h want 0 2351", we[0], data[0]);
    end
    finish = 1;
    tick();
    finish = 0;
    vectors++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_done: done=%b busy=%b want 1 0", dn[0], bsy[0]);
    end
    tick();
    vectors++;
    if (dn[0] !== 1'b0 || wc[0] !== 9'd1) begin
      miscompares++;
      $display("FAIL reg_done_once: done=%b wc=%0d want 0 1", dn[0], wc[0]);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    inValid = 1; immFormat = 1; opcode = 4'hA; rd = 4'd7; imm = 8'h3C; rs1 = 4'hF; rs2 = 4'hF;
    tick();
    vectors++;
    if (we[0] !== 1'b1 || addr[0] !== 8'h00 || data[0] !== 16'hA73C) begin
      miscompares++;
      $display("FAIL imm_first: we=%b addr=%h data=%h want 1 00 A73C", we[0], addr[0], data[0]);
    end
    opcode = 4'h1; rd = 4'd2; imm = 8'hFF;
    tick();
    inValid = 0;
    vectors++;
    if (we[0] !== 1'b1 || addr[0] !== 8'h01 || data[0] !== 16'h12FF || wc[0] !== 9'd2) begin
      miscompares++;
      $display("FAIL imm_second: we=%b addr=%h data=%h wc=%0d want 1 01 12FF 2", we[0], addr[0], data[0], wc[0]);
    end
    close_session();
  endtask

  task automatic test_full_boundary();
    pulse_start();
    inValid = 1;
    for (int i = 0; i < 5; i++) begin
      immFormat = 1'($urandom); opcode = 4'($urandom); rd = 4'($urandom);
      rs1 = 4'($urandom); rs2 = 4'($urandom); imm = 8'($urandom);
      tick();
      vectors++;
      if (i < 4) begin
        if (we[1] !== 1'b1 || addr[1] !== 8'(i) || wc[1] !== 9'(i + 1)) begin
          miscompares++;
          $display("FAIL full_write[%0d]: we=%b addr=%h wc=%0d want 1 %h %0d", i, we[1], addr[1], wc[1], 8'(i), i + 1);
        end
        if (i == 3) begin
          vectors++;
          if (ful[1] !== 1'b1 || rdy[1] !== 1'b0 || err[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL full_enter: full=%b inReady=%b err=%b want 1 0 0", ful[1], rdy[1], err[1]);
          end
        end
      end else begin
        if (we[1] !== 1'b0 || err[1] !== 1'b1 || ful[1] !== 1'b1 || wc[1] !== 9'd4) begin
          miscompares++;
          $display("FAIL full_overrun: we=%b err=%b full=%b wc=%0d want 0 1 1 4", we[1], err[1], ful[1], wc[1]);
        end
      end
    end
    inValid = 0;
    finish = 1;
    tick();
    finish = 0;
    vectors++;
    if (dn[1] !== 1'b1 || bsy[1] !== 1'b0 || ful[1] !== 1'b0 || wc[1] !== 9'd4) begin
      miscompares++;
      $display("FAIL full_finish: done=%b busy=%b full=%b wc=%0d want 1 0 0 4", dn[1], bsy[1], ful[1], wc[1]);
    end
    tick();
  endtask

  task automatic test_finish_with_accept();
    pulse_start();
    inValid = 1; immFormat = 0; opcode = 4'h5; rd = 4'd1; rs1 = 4'd2; rs2 = 4'd3;
    tick();
    tick();
    finish = 1; opcode = 4'hC; rd = 4'd4; rs2 = 4'd6; rs1 = 4'd9;
    tick();
    finish = 0; inValid = 0;
    vectors++;
    if (we[0] !== 1'b1 || addr[0] !== 8'h02 || data[0] !== 16'hC469 || dn[0] !== 1'b1 || wc[0] !== 9'd3 || bsy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL finish_accept: we=%b addr=%h data=%h done=%b wc=%0d busy=%b want 1 02 C469 1 3 0",
               we[0], addr[0], data[0], dn[0], wc[0], bsy[0]);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] want [4];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    pulse_start();
    inValid = 1; immFormat = 1;
    for (int i = 0; i < 4; i++) begin
      opcode = 4'(i); rd = 4'(i + 8); imm = 8'($urandom);
      tick();
      vectors++;
      if (we[2] !== 1'b1 || addr[2] !== want[i]) begin
        miscompares++;
        $display("FAIL wrap[%0d]: we=%b addr=%h want 1 %h", i, we[2], addr[2], want[i]);
      end
    end
    close_session();
  endtask

  task automatic test_reset_mid_session();
    inValid = 1;
    tick();
    inValid = 0;
    vectors++;
    if (err[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_error: err=%b want 1", err[0]);
    end
    pulse_start();
    inValid = 1; immFormat = 0; opcode = 4'h7; rd = 4'd7; rs1 = 4'd7; rs2 = 4'd7;
    tick();
    vectors++;
    if (we[0] !== 1'b1 || data[0] !== 16'h7777) begin
      miscompares++;
      $display("FAIL pre_reset_write: we=%b data=%h want 1 7777", we[0], data[0]);
    end
    inValid = 0;
    reset = 0;
    tick();
    vectors++;
    if (we[0] !== 1'b0 || rdy[0] !== 1'b0 || addr[0] !== 8'h00 || data[0] !== 16'h0 ||
        wc[0] !== 9'd0 || bsy[0] !== 1'b0 || ful[0] !== 1'b0 || dn[0] !== 1'b0 || err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: we=%b rdy=%b addr=%h data=%h wc=%0d busy=%b full=%b done=%b err=%b want all zero",
               we[0], rdy[0], addr[0], data[0], wc[0], bsy[0], ful[0], dn[0], err[0]);
    end
    reset = 1;
    tick();
    pulse_start();
    vectors++;
    if (rdy[0] !== 1'b1 || err[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: inReady=%b err=%b busy=%b want 1 0 1", rdy[0], err[0], bsy[0]);
    end
    close_session();
  endtask

  task automatic test_random();
    int shown = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        vectors++;
        if (rdy[k] !== m_ready(k) || we[k] !== m_we[k] || addr[k] !== 8'(m_addr[k]) ||
            data[k] !== 16'(m_data[k]) || wc[k] !== 9'(m_cnt[k]) || bsy[k] !== m_open[k] ||
            ful[k] !== (m_open[k] && m_cnt[k] == DEP[k]) || dn[k] !== m_end[k] || err[k] !== m_err[k]) begin
          miscompares++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random[c%0d,u%0d]: got rdy=%b we=%b addr=%h data=%h wc=%0d busy=%b full=%b done=%b err=%b; want rdy=%b we=%b addr=%h data=%h wc=%0d busy=%b full=%b done=%b err=%b",
                     c, k, rdy[k], we[k], addr[k], data[k], wc[k], bsy[k], ful[k], dn[k], err[k],
                     m_ready(k), m_we[k], 8'(m_addr[k]), 16'(m_data[k]), m_cnt[k], m_open[k],
                     (m_open[k] && m_cnt[k] == DEP[k]), m_end[k], m_err[k]);
          end
        end
      end
      reset     = ($urandom_range(0, 79) != 0);
      start     = ($urandom_range(0, 7) == 0);
      finish    = ($urandom_range(0, 19) == 0);
      inValid   = ($urandom_range(0, 2) != 0);
      immFormat = 1'($urandom);
      opcode    = 4'($urandom);
      rd        = 4'($urandom);
      rs1       = 4'($urandom);
      rs2       = 4'($urandom);
      imm       = 8'($urandom);
      tick();
    end
    clear_inputs();
    reset = 1;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clock);
    test_reset();
    test_register_encode();
    test_back_to_back();
    test_full_boundary();
    test_finish_with_accept();
    test_wrap();
    test_reset_mid_session();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields (opcode, destination, source registers or 8-bit immediate) back into 16-bit instruction words and streams them into instruction memory through a registered write port. It is the write-side counterpart of the decode stage and is used by the program loader and self-test sequencer to build programs in memory. A session is framed by `start`/`finish`, and a write-pointer/word-count pair bounds the session to `DEPTH` words.

## Interface
Parameters:
- INSTRUCTIONWIDTH, 16, instruction word width
- OPCODEWIDTH, 4, opcode field width
- ADDRESSWIDTH, 4, register-address field width; register 15 is the PC
- MEMADDRWIDTH, 8, instruction-memory address width
- DEPTH, 256, maximum words per session (1..2^MEMADDRWIDTH)
- BASEADDRESS, 0, first memory address written in a session

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle pulse; opens a session
- finish  in  1  one-cycle pulse; closes the session
- inValid  in  1  field bundle valid
- inReady  out  1  encoder accepts the bundle this cycle
- immFormat  in  1  1 = immediate format, 0 = register format
- opcode  in  OPCODEWIDTH  opcode field
- rd, rs1, rs2  in  ADDRESSWIDTH each  register fields
- imm  in  8  immediate field
- memWriteEnable  out  1  write strobe
- memAddress  out  MEMADDRWIDTH  write address
- memData  out  INSTRUCTIONWIDTH  encoded word
- wordCount  out  MEMADDRWIDTH+1  words written this session
- busy  out  1  state is RUN or FULL
- full  out  1  state is FULL
- done  out  1  one-cycle session-end pulse
- error  out  1  sticky protocol-violation flag

## Operation
- Register format: memData = {opcode, rd, rs2, rs1}. Immediate format: memData = {opcode, rd, imm}. rs1/rs2 are ignored in immediate format; imm is ignored in register format.
- The FSM has four states:
  - IDLE: start → RUN. A start pulse clears wordCount, sets the pointer to BASEADDRESS, and clears error.
  - RUN: inReady = 1.
    - Handshake: inValid && inReady accepts the bundle. The pointer and wordCount increment.
    - If the accept makes wordCount equal DEPTH, the next state is FULL.
    - finish → DONE. If finish and an accept occur in the same cycle, the word is written and the session ends.
    - finish takes priority over the transition to FULL.
  - FULL: inReady = 0. finish → DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE. inReady = 0.
- start outside IDLE is ignored.
- error sets when inValid = 1 while inReady = 0 in IDLE, FULL or DONE (overrun or no session). It clears only on reset or on an accepted start.
- memAddress = BASEADDRESS + offset, modulo 2^MEMADDRWIDTH, so the address wraps.
- wordCount saturates at DEPTH. It holds after the session and is cleared only by start or reset.
- Input fields are sampled only on an accept edge; they are don't-care otherwise.

## Timing
- Reset (reset = 0 at a clock edge) forces:
  - state IDLE, inReady = 0
  - memWriteEnable = 0, memAddress = BASEADDRESS, memData = 0
  - wordCount = 0, busy = 0, full = 0, done = 0, error = 0
- Reset mid-session drops any pending write. No memWriteEnable is issued in the cycle after the reset edge.
- Latency is 1 cycle: an accept at edge N drives memWriteEnable = 1 with the word and its address during cycle N+1. Throughput is one word per cycle.
- memWriteEnable is high only the cycle after an accept. memAddress and memData hold their last values otherwise.
- start at edge N makes inReady = 1 in cycle N+1.
- FULL is entered at the same edge as the DEPTH-th accept, so inReady = 0 in the cycle that the last word is written.
- done is asserted in the cycle after the finish edge. busy falls in the same cycle.

## Test plan
- Register encode: start; accept immFormat=0, opcode=4'h2, rd=3, rs2=5, rs1=1 → next cycle memWriteEnable=1, memAddress=0, memData=16'h2351; wordCount=1.
- Immediate encode, back-to-back: accept opcode=4'hA, rd=7, imm=8'h3C then opcode=4'h1, rd=2, imm=8'hFF on consecutive cycles → writes 16'hA73C @0 and 16'h12FF @1 in consecutive cycles; wordCount=2.
- Full boundary (DEPTH=4): 5 consecutive inValid → 4 writes @0..3, full=1, inReady=0 during the 5th cycle, error=1; finish → done pulse, busy=0, wordCount=4.
- finish with simultaneous accept: third word accepted in the same cycle as finish → write @2 occurs, done pulses the cycle after finish, wordCount=3.
- Wrap (BASEADDRESS=8'hFE, DEPTH=4): 4 accepts → memAddress sequence FE, FF, 00, 01.
- Reset mid-session: accept at edge N, reset=0 at edge N+1 → memWriteEnable=0 after edge N+1, all outputs at reset values; start after release → inReady=1, error=0.
